// File: rtl/l1_l2_arbiter_pkg.sv
// Shared types for the L1/L2 port arbiter: line/address aliases, FSM state
// encoding and the width helper for the D-streak counter.
package l1_l2_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;
    typedef logic [15:0]  lc3b_pmem_addr;

    typedef enum bit [1:0] {
        arb_idle,
        arb_serve_i,
        arb_serve_d
    } lc3b_arb_state;

    // A zero-width counter is illegal, so fairness-off still gets one bit.
    function automatic int streak_width(input int max_streak);
        return (max_streak > 0) ? $clog2(max_streak + 1) : 1;
    endfunction

endpackage

// File: rtl/l1_l2_arbiter_streak_counter.sv
// Saturating count of consecutive D grants made while the I-cache was waiting;
// sat tells the arbiter it must hand the next tie to the I-cache.
module arb_streak_counter
    import l1_l2_arbiter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int W = streak_width(MAX);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != MAX_V)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign sat = (count_reg == MAX_V);

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares one L2 port between the L1 I- and D-caches, one transaction at a
// time; D wins ties until its streak against a waiting I hits MAX_D_STREAK.
module l1_l2_arbiter
    import l1_l2_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          icache_pmem_read,
    input  lc3b_pmem_addr icache_pmem_address,
    output lc3b_mem_data  icache_pmem_rdata,
    output logic          icache_pmem_resp,
    input  logic          dcache_pmem_read,
    input  logic          dcache_pmem_write,
    input  lc3b_pmem_addr dcache_pmem_address,
    input  lc3b_mem_data  dcache_pmem_wdata,
    output lc3b_mem_data  dcache_pmem_rdata,
    output logic          dcache_pmem_resp,
    output logic          l2_read,
    output logic          l2_write,
    output lc3b_pmem_addr l2_address,
    output lc3b_mem_data  l2_wdata,
    input  lc3b_mem_data  l2_rdata,
    input  logic          l2_resp
);

    lc3b_arb_state state_reg, state_next;
    logic          op_write_reg, op_write_next;
    lc3b_pmem_addr addr_reg, addr_next;
    lc3b_mem_data  wdata_reg, wdata_next;

    logic d_pending, i_pending, d_wins;
    logic streak_inc, streak_clr, streak_sat;

    arb_streak_counter #(.MAX(MAX_D_STREAK)) u_streak (
        .clk   (clk),
        .reset (reset),
        .inc   (streak_inc),
        .clr   (streak_clr),
        .sat   (streak_sat)
    );

    assign d_pending = dcache_pmem_read | dcache_pmem_write;
    assign i_pending = icache_pmem_read;
    assign d_wins    = d_pending &&
                       (!i_pending || !streak_sat || (MAX_D_STREAK == 0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= arb_idle;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            op_write_reg <= op_write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        op_write_next     = op_write_reg;
        addr_next         = addr_reg;
        wdata_next        = wdata_reg;
        streak_inc        = 1'b0;
        streak_clr        = 1'b0;
        icache_pmem_rdata = '0;
        icache_pmem_resp  = 1'b0;
        dcache_pmem_rdata = '0;
        dcache_pmem_resp  = 1'b0;
        l2_read           = 1'b0;
        l2_write          = 1'b0;
        l2_address        = '0;
        l2_wdata          = '0;

        case (state_reg)
            arb_idle: begin
                if (d_wins) begin
                    state_next    = arb_serve_d;
                    addr_next     = dcache_pmem_address;
                    wdata_next    = dcache_pmem_wdata;
                    // Read+write together is illegal; the write takes precedence.
                    op_write_next = dcache_pmem_write;
                    streak_inc    = i_pending;
                    streak_clr    = !i_pending;
                end else if (i_pending) begin
                    state_next    = arb_serve_i;
                    addr_next     = icache_pmem_address;
                    wdata_next    = '0;
                    op_write_next = 1'b0;
                    streak_clr    = 1'b1;
                end
            end
            arb_serve_i: begin
                l2_read    = !op_write_reg;
                l2_write   = op_write_reg;
                l2_address = addr_reg;
                l2_wdata   = wdata_reg;
                if (l2_resp) begin
                    icache_pmem_resp  = 1'b1;
                    icache_pmem_rdata = l2_rdata;
                    state_next        = arb_idle;
                end
            end
            arb_serve_d: begin
                l2_read    = !op_write_reg;
                l2_write   = op_write_reg;
                l2_address = addr_reg;
                l2_wdata   = wdata_reg;
                if (l2_resp) begin
                    dcache_pmem_resp  = 1'b1;
                    dcache_pmem_rdata = l2_rdata;
                    state_next        = arb_idle;
                end
            end
            default: state_next = arb_idle;
        endcase

        // Reset silences the port immediately, even mid-transaction.
        if (reset) begin
            icache_pmem_rdata = '0;
            icache_pmem_resp  = 1'b0;
            dcache_pmem_rdata = '0;
            dcache_pmem_resp  = 1'b0;
            l2_read           = 1'b0;
            l2_write          = 1'b0;
            l2_address        = '0;
            l2_wdata          = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(dcache_pmem_read && dcache_pmem_write))
                else $warning("dcache read and write asserted together; treated as write");
        end
    end

endmodule
